battle_board_ctrl: RTL and testbench

//  Parametrised N x N battleship board: cursor-driven ship placement, then a shot

---
 rtl/battle_pkg.sv | 26 ++
 rtl/cursor_ctrl.sv | 63 ++++++
 rtl/battle_board_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_battle_board_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared types for the battleship board: cell contents, game states and the
// fleet-size clamp used when a game is started.
package battle_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    MISS  = 2'd2,
    HIT   = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    ARMED = 2'd2,
    LOST  = 2'd3
  } game_state_t;

  // A game always has at least one ship and never more than the board supports.
  function automatic int clamp_ships(input int requested, input int max_ships);
    if (requested < 1) return 1;
    if (requested > max_ships) return max_ships;
    return requested;
  endfunction

endpackage

// File: rtl/cursor_ctrl.sv
// Placement cursor: one move per cycle, priority up > down > left > right.
// At the board edge the cursor either saturates or wraps modulo BOARD_N.
module cursor_ctrl #(
  parameter int BOARD_N     = 5,
  parameter bit WRAP_CURSOR = 1'b0,
  localparam int IDX_W      = $clog2(BOARD_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             move_up,
  input  logic             move_down,
  input  logic             move_left,
  input  logic             move_right,
  output logic [IDX_W-1:0] cursor_i,
  output logic [IDX_W-1:0] cursor_j
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(BOARD_N - 1);

  logic [IDX_W-1:0] i_reg, i_next;
  logic [IDX_W-1:0] j_reg, j_next;

  // Next cursor position: clear wins, then the highest-priority move pulse.
  always_comb begin
    i_next = i_reg;
    j_next = j_reg;
    if (clr) begin
      i_next = '0;
      j_next = '0;
    end else if (en) begin
      if (move_up) begin
        if (i_reg == '0) i_next = WRAP_CURSOR ? LAST : '0;
        else             i_next = i_reg - IDX_W'(1);
      end else if (move_down) begin
        if (i_reg == LAST) i_next = WRAP_CURSOR ? '0 : LAST;
        else               i_next = i_reg + IDX_W'(1);
      end else if (move_left) begin
        if (j_reg == '0) j_next = WRAP_CURSOR ? LAST : '0;
        else             j_next = j_reg - IDX_W'(1);
      end else if (move_right) begin
        if (j_reg == LAST) j_next = WRAP_CURSOR ? '0 : LAST;
        else               j_next = j_reg + IDX_W'(1);
      end
    end
  end

  // Cursor registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_reg <= '0;
      j_reg <= '0;
    end else begin
      i_reg <= i_next;
      j_reg <= j_next;
    end
  end

  assign cursor_i = i_reg;
  assign cursor_j = j_reg;

endmodule

// File: rtl/battle_board_ctrl.sv
// Battleship board controller: cursor-driven ship placement followed by a
// shot port that scores shots, counts down the fleet and flags fleet loss.
// The board is a register array with one write port and combinational reads
// for the cursor, the shot address and the renderer.
module battle_board_ctrl
  import battle_pkg::*;
#(
  parameter int BOARD_N     = 5,
  parameter int MAX_SHIPS   = 5,
  parameter bit WRAP_CURSOR = 1'b0,
  localparam int IDX_W      = $clog2(BOARD_N),
  localparam int CNT_W      = $clog2(MAX_SHIPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ships,
  input  logic             move_up,
  input  logic             move_down,
  input  logic             move_left,
  input  logic             move_right,
  input  logic             place,
  input  logic             shot_valid,
  input  logic [IDX_W-1:0] shot_i,
  input  logic [IDX_W-1:0] shot_j,
  output logic             shot_ready,
  output logic             result_valid,
  output logic             result_hit,
  output logic             result_repeat,
  input  logic [IDX_W-1:0] rd_i,
  input  logic [IDX_W-1:0] rd_j,
  output logic [1:0]       rd_cell,
  output logic [IDX_W-1:0] cursor_i,
  output logic [IDX_W-1:0] cursor_j,
  output logic [CNT_W-1:0] ships_placed,
  output logic [CNT_W-1:0] ships_left,
  output logic             place_err,
  output logic [1:0]       state_o
);

  game_state_t      state_reg, state_next;
  logic [CNT_W-1:0] target_reg, target_next;
  logic [CNT_W-1:0] placed_reg, placed_next;
  logic [CNT_W-1:0] left_reg, left_next;
  logic             shot_ready_reg, shot_ready_next;
  logic             res_valid_reg, res_valid_next;
  logic             res_hit_reg, res_hit_next;
  logic             res_rep_reg, res_rep_next;
  logic             place_err_reg, place_err_next;

  cell_t            board_reg [BOARD_N][BOARD_N];

  logic             wr_en;
  logic             board_clr;
  logic [IDX_W-1:0] wr_i, wr_j;
  cell_t            wr_data;
  logic             start_acc;
  logic             shot_acc;
  logic             shot_in_range;
  cell_t            cursor_cell, shot_cell, render_cell;

  cursor_ctrl #(
    .BOARD_N    (BOARD_N),
    .WRAP_CURSOR(WRAP_CURSOR)
  ) u_cursor (
    .clk       (clk),
    .rst       (rst),
    .en        (state_reg == PLACE),
    .clr       (start_acc),
    .move_up   (move_up),
    .move_down (move_down),
    .move_left (move_left),
    .move_right(move_right),
    .cursor_i  (cursor_i),
    .cursor_j  (cursor_j)
  );

  // Read ports: address decode by comparison so out-of-range reads give EMPTY.
  always_comb begin
    cursor_cell = EMPTY;
    shot_cell   = EMPTY;
    render_cell = EMPTY;
    for (int a = 0; a < BOARD_N; a++) begin
      for (int b = 0; b < BOARD_N; b++) begin
        if (cursor_i == IDX_W'(a) && cursor_j == IDX_W'(b)) cursor_cell = board_reg[a][b];
        if (shot_i == IDX_W'(a) && shot_j == IDX_W'(b))     shot_cell   = board_reg[a][b];
        if (rd_i == IDX_W'(a) && rd_j == IDX_W'(b))         render_cell = board_reg[a][b];
      end
    end
  end

  assign shot_in_range = (int'(shot_i) < BOARD_N) && (int'(shot_j) < BOARD_N);

  // Game FSM, counters, shot scoring and board write request.
  always_comb begin
    state_next     = state_reg;
    target_next    = target_reg;
    placed_next    = placed_reg;
    left_next      = left_reg;
    res_valid_next = 1'b0;
    res_hit_next   = res_hit_reg;
    res_rep_next   = res_rep_reg;
    place_err_next = 1'b0;
    wr_en          = 1'b0;
    wr_i           = cursor_i;
    wr_j           = cursor_j;
    wr_data        = SHIP;
    board_clr      = 1'b0;
    start_acc      = 1'b0;
    shot_acc       = 1'b0;
    case (state_reg)
      IDLE, LOST: begin
        if (start) begin
          start_acc   = 1'b1;
          board_clr   = 1'b1;
          state_next  = PLACE;
          target_next = CNT_W'(clamp_ships(int'(num_ships), MAX_SHIPS));
          placed_next = '0;
          left_next   = '0;
        end
      end
      PLACE: begin
        // The cursor register still holds the pre-move position here.
        if (place) begin
          if (cursor_cell == SHIP) begin
            place_err_next = 1'b1;
          end else begin
            wr_en       = 1'b1;
            placed_next = placed_reg + CNT_W'(1);
            if (placed_next == target_reg) begin
              state_next = ARMED;
              left_next  = target_reg;
            end
          end
        end
      end
      ARMED: begin
        if (shot_valid && shot_ready_reg) begin
          shot_acc       = 1'b1;
          res_valid_next = 1'b1;
          wr_i           = shot_i;
          wr_j           = shot_j;
          if (!shot_in_range || shot_cell == MISS || shot_cell == HIT) begin
            res_hit_next = 1'b0;
            res_rep_next = 1'b1;
          end else if (shot_cell == SHIP) begin
            res_hit_next = 1'b1;
            res_rep_next = 1'b0;
            wr_en        = 1'b1;
            wr_data      = HIT;
            left_next    = left_reg - CNT_W'(1);
            if (left_reg == CNT_W'(1)) state_next = LOST;
          end else begin
            res_hit_next = 1'b0;
            res_rep_next = 1'b0;
            wr_en        = 1'b1;
            wr_data      = MISS;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Ready is withheld for the cycle after an accept and whenever not armed.
    shot_ready_next = (state_next == ARMED) && !shot_acc;
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      target_reg     <= '0;
      placed_reg     <= '0;
      left_reg       <= '0;
      shot_ready_reg <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_hit_reg    <= 1'b0;
      res_rep_reg    <= 1'b0;
      place_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      target_reg     <= target_next;
      placed_reg     <= placed_next;
      left_reg       <= left_next;
      shot_ready_reg <= shot_ready_next;
      res_valid_reg  <= res_valid_next;
      res_hit_reg    <= res_hit_next;
      res_rep_reg    <= res_rep_next;
      place_err_reg  <= place_err_next;
    end
  end

  // Board storage: full clear on reset or game start, otherwise one cell write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < BOARD_N; a++)
        for (int b = 0; b < BOARD_N; b++)
          board_reg[a][b] <= EMPTY;
    end else if (board_clr) begin
      for (int a = 0; a < BOARD_N; a++)
        for (int b = 0; b < BOARD_N; b++)
          board_reg[a][b] <= EMPTY;
    end else if (wr_en) begin
      for (int a = 0; a < BOARD_N; a++)
        for (int b = 0; b < BOARD_N; b++)
          if (wr_i == IDX_W'(a) && wr_j == IDX_W'(b))
            board_reg[a][b] <= wr_data;
    end
  end

  assign shot_ready    = shot_ready_reg;
  assign result_valid  = res_valid_reg;
  assign result_hit    = res_hit_reg;
  assign result_repeat = res_rep_reg;
  assign rd_cell       = render_cell;
  assign ships_placed  = placed_reg;
  assign ships_left    = left_reg;
  assign place_err     = place_err_reg;
  assign state_o       = state_reg;

endmodule

// File: tb/tb_battle_board_ctrl.sv
// Bench for battle_board_ctrl: a saturating-cursor board and a wrapping-cursor
// board share stimulus; the placement phase is table driven, shots, fleet loss,
// restart and mid-game reset are hand-written sequences.
module tb_battle_board_ctrl;
  import battle_pkg::*;

  localparam int BOARD_N   = 5;
  localparam int MAX_SHIPS = 5;
  localparam int IDX_W     = 3;
  localparam int CNT_W     = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_ships = '0;
  logic             move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
  logic             place = 1'b0;
  logic             shot_valid = 1'b0;
  logic [IDX_W-1:0] shot_i = '0, shot_j = '0;
  logic [IDX_W-1:0] rd_i = '0, rd_j = '0;

  logic             shot_ready, result_valid, result_hit, result_repeat, place_err;
  logic [1:0]       rd_cell, state_o;
  logic [IDX_W-1:0] cursor_i, cursor_j;
  logic [CNT_W-1:0] ships_placed, ships_left;

  logic             w_shot_ready, w_result_valid, w_result_hit, w_result_repeat, w_place_err;
  logic [1:0]       w_rd_cell, w_state_o;
  logic [IDX_W-1:0] w_cursor_i, w_cursor_j;
  logic [CNT_W-1:0] w_ships_placed, w_ships_left;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  battle_board_ctrl #(.BOARD_N(BOARD_N), .MAX_SHIPS(MAX_SHIPS), .WRAP_CURSOR(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .num_ships(num_ships),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .place(place), .shot_valid(shot_valid), .shot_i(shot_i), .shot_j(shot_j),
    .shot_ready(shot_ready), .result_valid(result_valid), .result_hit(result_hit),
    .result_repeat(result_repeat), .rd_i(rd_i), .rd_j(rd_j), .rd_cell(rd_cell),
    .cursor_i(cursor_i), .cursor_j(cursor_j), .ships_placed(ships_placed),
    .ships_left(ships_left), .place_err(place_err), .state_o(state_o)
  );

  battle_board_ctrl #(.BOARD_N(BOARD_N), .MAX_SHIPS(MAX_SHIPS), .WRAP_CURSOR(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .num_ships(num_ships),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .place(place), .shot_valid(shot_valid), .shot_i(shot_i), .shot_j(shot_j),
    .shot_ready(w_shot_ready), .result_valid(w_result_valid), .result_hit(w_result_hit),
    .result_repeat(w_result_repeat), .rd_i(rd_i), .rd_j(rd_j), .rd_cell(w_rd_cell),
    .cursor_i(w_cursor_i), .cursor_j(w_cursor_j), .ships_placed(w_ships_placed),
    .ships_left(w_ships_left), .place_err(w_place_err), .state_o(w_state_o)
  );

  typedef struct {
    int st, up, dn, lf, rt, pl;
    int ci, cj, placed, err, state, wi, wj;
  } row_t;

  row_t vec [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic rd_check(input string name, input int i, input int j, input int e);
    rd_i = IDX_W'(i);
    rd_j = IDX_W'(j);
    #1;
    check(name, 32'(rd_cell), e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0; move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    place = 1'b0;
  endtask

  // Drive one shot, wait (bounded) for acceptance, check the result pulse
  // and the cycle after it.
  task automatic do_shot(input int si, input int sj, input int eh, input int er,
                         input int el, input int est);
    int n = 0;
    shot_i = IDX_W'(si);
    shot_j = IDX_W'(sj);
    shot_valid = 1'b1;
    while (!shot_ready && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("shot(%0d,%0d) ready", si, sj), 32'(shot_ready), 1);
    @(posedge clk);
    #1;
    shot_valid = 1'b0;
    check($sformatf("shot(%0d,%0d) result_valid", si, sj), 32'(result_valid), 1);
    check($sformatf("shot(%0d,%0d) hit", si, sj), 32'(result_hit), eh);
    check($sformatf("shot(%0d,%0d) repeat", si, sj), 32'(result_repeat), er);
    check($sformatf("shot(%0d,%0d) ships_left", si, sj), 32'(ships_left), el);
    check($sformatf("shot(%0d,%0d) state", si, sj), 32'(state_o), est);
    check($sformatf("shot(%0d,%0d) ready dropped", si, sj), 32'(shot_ready), 0);
    @(posedge clk);
    #1;
    check($sformatf("shot(%0d,%0d) pulse ends", si, sj), 32'(result_valid), 0);
    check($sformatf("shot(%0d,%0d) hit held", si, sj), 32'(result_hit), eh);
    check($sformatf("shot(%0d,%0d) ready after", si, sj), 32'(shot_ready), (est == 2) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    //            st up dn lf rt pl   ci cj pl er st  wi wj
    vec[0]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  4, 0};
    vec[1]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  3, 0};
    vec[2]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1,  2, 0};
    vec[3]  = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1,  2, 4};
    vec[4]  = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1,  2, 3};
    vec[5]  = '{0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1,  1, 3};
    vec[6]  = '{1, 0, 1, 0, 0, 0,  1, 0, 0, 0, 1,  2, 3};
    vec[7]  = '{0, 0, 1, 0, 0, 0,  2, 0, 0, 0, 1,  3, 3};
    vec[8]  = '{0, 0, 0, 0, 1, 0,  2, 1, 0, 0, 1,  3, 4};
    vec[9]  = '{0, 0, 0, 0, 1, 0,  2, 2, 0, 0, 1,  3, 0};
    vec[10] = '{0, 0, 0, 0, 1, 0,  2, 3, 0, 0, 1,  3, 1};
    vec[11] = '{0, 0, 0, 0, 0, 1,  2, 3, 1, 0, 1,  3, 1};
    vec[12] = '{0, 0, 0, 0, 0, 1,  2, 3, 1, 1, 1,  3, 1};
    vec[13] = '{0, 0, 0, 1, 0, 0,  2, 2, 1, 0, 1,  3, 0};
    vec[14] = '{0, 0, 1, 0, 0, 1,  3, 2, 2, 0, 1,  4, 0};
    vec[15] = '{0, 0, 0, 0, 0, 1,  3, 2, 3, 0, 1,  4, 0};
    vec[16] = '{0, 0, 1, 0, 0, 0,  4, 2, 3, 0, 1,  0, 0};
    vec[17] = '{0, 0, 0, 0, 0, 1,  4, 2, 4, 0, 1,  0, 0};
    vec[18] = '{0, 0, 0, 0, 1, 0,  4, 3, 4, 0, 1,  0, 1};
    vec[19] = '{0, 0, 0, 0, 0, 1,  4, 3, 5, 0, 2,  0, 1};
    vec[20] = '{0, 1, 0, 0, 0, 1,  4, 3, 5, 0, 2,  0, 1};

    // Reset state, while held and after release.
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 32'(state_o), 0);
    check("reset shot_ready", 32'(shot_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle state", 32'(state_o), 0);
    check("idle cursor_i", 32'(cursor_i), 0);
    check("idle cursor_j", 32'(cursor_j), 0);
    check("idle ships_placed", 32'(ships_placed), 0);
    check("idle ships_left", 32'(ships_left), 0);
    check("idle result_valid", 32'(result_valid), 0);
    check("idle place_err", 32'(place_err), 0);
    rd_check("idle rd(0,0)", 0, 0, 0);

    // Moves and place are ignored in IDLE.
    move_down = 1'b1; place = 1'b1;
    step();
    check("idle move ignored", 32'(cursor_i), 0);
    check("idle place ignored", 32'(ships_placed), 0);

    // Start with an oversized fleet request: clamped to MAX_SHIPS.
    num_ships = 3'd7;
    start = 1'b1;
    step();
    check("start -> PLACE", 32'(state_o), 1);
    check("wrap start -> PLACE", 32'(w_state_o), 1);

    for (int k = 0; k < 21; k++) begin
      start      = (vec[k].st != 0);
      move_up    = (vec[k].up != 0);
      move_down  = (vec[k].dn != 0);
      move_left  = (vec[k].lf != 0);
      move_right = (vec[k].rt != 0);
      place      = (vec[k].pl != 0);
      step();
      check($sformatf("row%0d cursor_i", k), 32'(cursor_i), vec[k].ci);
      check($sformatf("row%0d cursor_j", k), 32'(cursor_j), vec[k].cj);
      check($sformatf("row%0d ships_placed", k), 32'(ships_placed), vec[k].placed);
      check($sformatf("row%0d place_err", k), 32'(place_err), vec[k].err);
      check($sformatf("row%0d state", k), 32'(state_o), vec[k].state);
      check($sformatf("row%0d wrap cursor_i", k), 32'(w_cursor_i), vec[k].wi);
      check($sformatf("row%0d wrap cursor_j", k), 32'(w_cursor_j), vec[k].wj);
    end

    check("armed ships_left", 32'(ships_left), 5);
    check("armed shot_ready", 32'(shot_ready), 1);
    rd_check("rd(2,3) ship", 2, 3, 1);
    rd_check("rd(2,2) pre-move place", 2, 2, 1);
    rd_check("rd(3,2) ship", 3, 2, 1);
    rd_check("rd(2,1) empty", 2, 1, 0);
    rd_check("rd(7,7) out of range", 7, 7, 0);

    // Shots: hit, repeat, out of range, miss, repeat on miss, then sink the fleet.
    do_shot(2, 3, 1, 0, 4, 2);
    rd_check("rd(2,3) hit", 2, 3, 3);
    do_shot(2, 3, 0, 1, 4, 2);
    do_shot(7, 0, 0, 1, 4, 2);
    do_shot(0, 0, 0, 0, 4, 2);
    rd_check("rd(0,0) miss", 0, 0, 2);
    do_shot(0, 0, 0, 1, 4, 2);
    do_shot(2, 2, 1, 0, 3, 2);
    do_shot(3, 2, 1, 0, 2, 2);
    do_shot(4, 2, 1, 0, 1, 2);
    do_shot(4, 3, 1, 0, 0, 3);

    // LOST: board and cursor frozen, no shots accepted.
    move_up = 1'b1; place = 1'b1;
    step();
    check("lost cursor frozen", 32'(cursor_i), 4);
    check("lost placed frozen", 32'(ships_placed), 5);
    check("lost shot_ready", 32'(shot_ready), 0);
    rd_check("lost rd(4,3)", 4, 3, 3);

    // Restart from LOST with a zero request: clamped up to one ship.
    num_ships = 3'd0;
    start = 1'b1;
    step();
    check("restart state", 32'(state_o), 1);
    check("restart ships_placed", 32'(ships_placed), 0);
    check("restart ships_left", 32'(ships_left), 0);
    check("restart cursor_i", 32'(cursor_i), 0);
    check("restart cursor_j", 32'(cursor_j), 0);
    for (int a = 0; a < BOARD_N; a++)
      for (int b = 0; b < BOARD_N; b++)
        rd_check($sformatf("restart rd(%0d,%0d)", a, b), a, b, 0);
    place = 1'b1;
    step();
    check("min fleet armed", 32'(state_o), 2);
    check("min fleet ships_left", 32'(ships_left), 1);

    // Reset in the cycle after an accepted shot: the result is lost.
    shot_i = '0;
    shot_j = '0;
    shot_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    shot_valid = 1'b0;
    #1;
    check("rst result_valid", 32'(result_valid), 0);
    check("rst state", 32'(state_o), 0);
    check("rst ships_left", 32'(ships_left), 0);
    check("rst ships_placed", 32'(ships_placed), 0);
    check("rst shot_ready", 32'(shot_ready), 0);
    check("rst result_hit", 32'(result_hit), 0);
    rd_check("rst rd(0,0)", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post-rst result_valid", 32'(result_valid), 0);
    check("post-rst state", 32'(state_o), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
